// File: rtl/generic_dpram_1clk_pkg.sv
// Project-wide default geometry for the single-clock dual-port RAM.
// Instances override these through the aw/dw parameters.
package generic_dpram_1clk_pkg;
    localparam int unsigned DPRAM_AW_DEF = 8;
    localparam int unsigned DPRAM_DW_DEF = 8;
endpackage

// File: rtl/generic_dpram_1clk.sv
// Single-clock simple dual-port RAM: one write port and one registered-address read port.
// The read data is combinational from the address register, so a same-edge write to the read address is visible at once.
module generic_dpram_1clk
    import generic_dpram_1clk_pkg::*;
#(
    parameter int unsigned aw = DPRAM_AW_DEF,
    parameter int unsigned dw = DPRAM_DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rce,
    input  logic          oe,
    input  logic [aw-1:0] raddr,
    output logic [dw-1:0] dout,
    input  logic          wce,
    input  logic          we,
    input  logic [aw-1:0] waddr,
    input  logic [dw-1:0] din
);

    logic [dw-1:0] mem [0:(2**aw)-1];
    logic [aw-1:0] ra_d, ra_q;

    // Array is left unreset so it maps onto block RAM; writes are gated while rst is low.
    always_ff @(posedge clk) begin
        if (rst && wce && we) mem[waddr] <= din;
    end

    always_comb begin
        ra_d = ra_q;
        if (rce) ra_d = raddr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ra_q <= '0;
        else      ra_q <= ra_d;
    end

    assign dout = oe ? mem[ra_q] : '0;

endmodule

// File: tb/tb_generic_dpram_1clk.sv
// Directed bench for generic_dpram_1clk: expected read data is queued when stimulus is
// driven and popped/compared once the RAM presents it on dout.
module tb_generic_dpram_1clk;

    logic       clk = 1'b0;
    logic       rst, rce, oe, wce, we;
    logic [7:0] raddr, waddr, din, dout;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    generic_dpram_1clk #(8, 8) dut (
        .clk(clk), .rst(rst), .rce(rce), .oe(oe), .raddr(raddr), .dout(dout),
        .wce(wce), .we(we), .waddr(waddr), .din(din)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_push(input string tag, input logic [7:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_pop();
        sb_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: dout=%h expected=<none>", dout);
        end else begin
            e = sb_q.pop_front();
            assert (dout === e.exp) else begin
                n_fail++;
                $error("FAIL %s: dout=%h expected=%h", e.tag, dout, e.exp);
            end
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        waddr = a; din = d; wce = 1'b1; we = 1'b1;
        tick();
        wce = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        raddr = a; rce = 1'b1;
        expect_push(tag, exp);
        tick();
        check_pop();
    endtask

    initial begin
        rst = 1'b0; rce = 1'b1; oe = 1'b1; wce = 1'b0; we = 1'b0;
        raddr = 8'h00; waddr = 8'h00; din = 8'h00;
        tick(); tick();
        rst = 1'b1;
        tick();

        // reset release, first write to address 0, then oe gating
        expect_push("reset_first_write", 8'hA5);
        wr(8'h00, 8'hA5);
        check_pop();
        oe = 1'b0;
        #1;
        expect_push("oe_low", 8'h00);
        check_pop();
        oe = 1'b1;
        #1;
        expect_push("oe_high_again", 8'hA5);
        check_pop();

        // sequential fill and readback
        for (int i = 0; i < 256; i++) wr(i[7:0], i[7:0] ^ 8'h3C);
        for (int i = 0; i < 256; i++) rd("seq_read", i[7:0], i[7:0] ^ 8'h3C);

        // write enable gating
        wr(8'd7, 8'h11);
        waddr = 8'd7; din = 8'h22; wce = 1'b0; we = 1'b1;
        tick();
        wce = 1'b1; we = 1'b0;
        tick();
        wce = 1'b0; we = 1'b0;
        rd("we_wce_gating", 8'd7, 8'h11);

        // read clock enable low: address register holds
        rce = 1'b0; raddr = 8'd8;
        expect_push("rce_hold", 8'h11);
        tick();
        check_pop();
        tick();
        expect_push("rce_hold_2", 8'h11);
        check_pop();

        // read-during-write, same address is write-first
        wr(8'd9, 8'h01);
        rd("rdw_pre", 8'd9, 8'h01);
        raddr = 8'd9; rce = 1'b1;
        expect_push("rdw_same_addr", 8'hF0);
        wr(8'd9, 8'hF0);
        check_pop();
        expect_push("rdw_other_addr", 8'hF0);
        wr(8'd10, 8'h77);
        check_pop();
        rd("other_addr_written", 8'd10, 8'h77);

        // reset mid-operation
        rd("pre_reset_read", 8'd20, 8'd20 ^ 8'h3C);
        #2;
        rst = 1'b0;
        #1;
        expect_push("async_reset_dout", 8'h00 ^ 8'h3C);
        check_pop();
        raddr = 8'd20; rce = 1'b1;
        wr(8'd20, 8'hEE);
        expect_push("ra_held_in_reset", 8'h3C);
        check_pop();
        oe = 1'b0;
        #1;
        expect_push("oe_low_in_reset", 8'h00);
        check_pop();
        oe = 1'b1;
        rst = 1'b1;
        tick();
        rd("write_dropped_in_reset", 8'd20, 8'd20 ^ 8'h3C);
        rd("mem0_retained", 8'd0, 8'h3C);

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL scoreboard_leftover: remaining=%0d expected=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/generic_dpram_1clk.md
Name: generic_dpram_1clk

Overview:
- Single-clock, simple dual-port RAM with one write port and one registered-address read port.
- Storage element used by the FIFO and buffer blocks.
- Read and write are independent and may both occur in every cycle.

Parameters:
- aw, 8, address width; depth = 2**aw words. Positional order is aw first, then dw.
- dw, 8, data word width in bits.

Ports:
- clk  input  1  single clock for both ports; rising edge active.
- rst  input  1  asynchronous, active-low reset.
- rce  input  1  read clock enable; when high, raddr is captured on the clk edge.
- oe  input  1  output enable; when low, dout is forced to 0.
- raddr  input  aw  read address.
- dout  output  dw  read data.
- wce  input  1  write clock enable.
- we  input  1  write enable.
- waddr  input  aw  write address.
- din  input  dw  write data.

Behaviour:

Storage and write port:
- Storage is an array of 2**aw words of dw bits.
- The array is not reset; its contents are undefined until written.
- Write: on a rising clk edge with rst high, wce=1 and we=1, mem[waddr] <= din.
- Write is suppressed if either wce or we is 0.
- Write is suppressed while rst is low.

Read port:
- A read address register ra_q (aw bits) is loaded from raddr on the rising clk edge when rce=1.
- ra_q holds its value when rce=0.
- ra_q is cleared to 0 asynchronously when rst goes low and stays 0 while rst is low.
- dout = oe ? mem[ra_q] : 0. This path is combinational from ra_q, oe and the array, with no tri-state.
- Read latency: data for raddr presented before edge k is valid on dout after edge k (1 cycle).
- If the array changes at ra_q, dout follows without further address change.

Read-during-write:
- Same edge, raddr == waddr: dout after that edge shows the new data (write-first).
- Different addresses: fully independent, no interaction.

Reset:
- During and after reset, dout = mem[0] if oe=1, else 0.
- There is no other reset-visible output state.
- Reset asserted mid-operation: ra_q clears immediately; any write on an edge while rst is low is dropped; stored contents are retained.

Addressing:
- Addresses are aw bits wide; there is no out-of-range case and no wrap logic.

Decomposition:
- No shared package is required. Optionally, a project package holds default AW/DW constants.
- No sub-modules: one module containing the array, the write process, the read-address register and the output mux.
- The array should infer block RAM.

Test Plan:
- Reset and oe gating: assert rst=0, then write 0xA5 to address 0 after release and hold raddr=0, rce=1.
  - dout=0xA5 one cycle later.
  - Drive oe=0 -> dout=0x00 immediately.
- Sequential write/read: write din=addr^0x3C to addresses 0..255 (wce=we=1), then read 0..255 with rce=1.
  - Each dout equals addr^0x3C, appearing 1 cycle after raddr.
- Enable gating:
  - Write 0x11 to address 7, then attempt to write 0x22 with we=1, wce=0, and again with we=0, wce=1 -> read of address 7 returns 0x11.
  - Set rce=0 and change raddr -> dout does not change.
- Read-during-write: hold raddr=waddr=9 with address 9 holding 0x01, write 0xF0 on one edge -> dout=0xF0 after that edge.
  - Simultaneous write to 10 while reading 9 -> dout stays the address-9 value.
- Reset mid-operation: with ra_q=20, assert rst=0 asynchronously between edges.
  - dout switches immediately to mem[0].
  - A write attempted during reset is not stored; address 20 keeps its prior contents after release.
